// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file types and constants
package regfile_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;
  localparam int REG_DATA_WIDTH = 32;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] address;
    logic [REG_DATA_WIDTH-1:0] data;
  } wbEntry_t;

endpackage

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - two-in/two-out in-order writeback queue feeding the register file
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      resultValidA,
  output logic                      resultReadyA,
  input  logic [REG_ADDR_WIDTH-1:0] resultAddressA,
  input  logic [DATA_WIDTH-1:0]     resultDataA,
  input  logic                      resultValidB,
  output logic                      resultReadyB,
  input  logic [REG_ADDR_WIDTH-1:0] resultAddressB,
  input  logic [DATA_WIDTH-1:0]     resultDataB,
  input  logic                      writeStall,
  output logic                      writeEnableA,
  output logic [REG_ADDR_WIDTH-1:0] writeAddressA,
  output logic [DATA_WIDTH-1:0]     writeDataA,
  output logic                      writeEnableB,
  output logic [REG_ADDR_WIDTH-1:0] writeAddressB,
  output logic [DATA_WIDTH-1:0]     writeDataB,
  input  logic [REG_ADDR_WIDTH-1:0] lookupAddress,
  output logic                      pendingHit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [REG_ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [DEPTH];

  ptr_t          rd_ptr;
  ptr_t          wr_ptr;
  ptr_t          head_next;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          acc_a;
  logic          acc_b;
  logic          drain_one;
  logic          drain_two;
  logic [1:0]    n_enq;
  logic [1:0]    n_drain;

  // Free space is taken before this cycle's drain, so a full queue refuses even while draining.
  assign free         = CW'(DEPTH) - count;
  assign resultReadyA = (free != '0);
  assign resultReadyB = (free >= CW'(2)) || ((free == CW'(1)) && !resultValidA);

  assign acc_a     = resultValidA && resultReadyA;
  assign acc_b     = resultValidB && resultReadyB;
  assign drain_one = !writeStall && (count == CW'(1));
  assign drain_two = !writeStall && (count >= CW'(2));
  assign head_next = rd_ptr + ptr_t'(1);
  assign n_enq     = 2'(acc_a) + 2'(acc_b);
  assign n_drain   = drain_two ? 2'd2 : (drain_one ? 2'd1 : 2'd0);

  // Older entry goes to port B, younger to port A: port-A priority then keeps the youngest value.
  always_comb begin
    writeEnableA  = drain_one || drain_two;
    writeEnableB  = drain_two;
    writeAddressA = '0;
    writeDataA    = '0;
    writeAddressB = '0;
    writeDataB    = '0;
    if (drain_two) begin
      writeAddressA = addr_mem[head_next];
      writeDataA    = data_mem[head_next];
      writeAddressB = addr_mem[rd_ptr];
      writeDataB    = data_mem[rd_ptr];
    end else if (drain_one) begin
      writeAddressA = addr_mem[rd_ptr];
      writeDataA    = data_mem[rd_ptr];
    end
  end

  always_comb begin
    pendingHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(ptr_t'(ptr_t'(i) - rd_ptr)) < count) && (addr_mem[i] == lookupAddress)) begin
        pendingHit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + ptr_t'(n_drain);
      wr_ptr <= wr_ptr + ptr_t'(n_enq);
      count  <= count + CW'(n_enq) - CW'(n_drain);
    end
  end

  // Entry storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (acc_a) begin
      addr_mem[wr_ptr] <= resultAddressA;
      data_mem[wr_ptr] <= resultDataA;
    end
    if (acc_b) begin
      addr_mem[wr_ptr + ptr_t'(acc_a)] <= resultAddressB;
      data_mem[wr_ptr + ptr_t'(acc_a)] <= resultDataB;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - self-checking bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          resultValidA, resultValidB;
  logic          resultReadyA, resultReadyB;
  logic [4:0]    resultAddressA, resultAddressB;
  logic [DW-1:0] resultDataA, resultDataB;
  logic          writeStall;
  logic          writeEnableA, writeEnableB;
  logic [4:0]    writeAddressA, writeAddressB;
  logic [DW-1:0] writeDataA, writeDataB;
  logic [4:0]    lookupAddress;
  logic          pendingHit;

  int checks   = 0;
  int failures = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .resultValidA(resultValidA), .resultReadyA(resultReadyA),
    .resultAddressA(resultAddressA), .resultDataA(resultDataA),
    .resultValidB(resultValidB), .resultReadyB(resultReadyB),
    .resultAddressB(resultAddressB), .resultDataB(resultDataB),
    .writeStall(writeStall),
    .writeEnableA(writeEnableA), .writeAddressA(writeAddressA), .writeDataA(writeDataA),
    .writeEnableB(writeEnableB), .writeAddressB(writeAddressB), .writeDataB(writeDataB),
    .lookupAddress(lookupAddress), .pendingHit(pendingHit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic va; logic [4:0] aa; logic [31:0] da;
    logic vb; logic [4:0] ab; logic [31:0] db;
    logic st; logic [4:0] lk;
    logic ra; logic rb;
    logic wea; logic [4:0] waa; logic [31:0] wda;
    logic web; logic [4:0] wab; logic [31:0] wdb;
    logic hit;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t        vecs[$];
  ent_t        q[$];
  logic [31:0] rf   [32];
  logic [31:0] last [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic va, input logic [4:0] aa, input logic [31:0] da,
                             input logic vb, input logic [4:0] ab, input logic [31:0] db,
                             input logic st, input logic [4:0] lk, input logic ra, input logic rb,
                             input logic wea, input logic [4:0] waa, input logic [31:0] wda,
                             input logic web, input logic [4:0] wab, input logic [31:0] wdb,
                             input logic hit);
    vec_t r;
    r.va = va; r.aa = aa; r.da = da; r.vb = vb; r.ab = ab; r.db = db;
    r.st = st; r.lk = lk; r.ra = ra; r.rb = rb;
    r.wea = wea; r.waa = waa; r.wda = wda; r.web = web; r.wab = wab; r.wdb = wdb;
    r.hit = hit;
    return r;
  endfunction

  task automatic drive(input logic va, input logic [4:0] aa, input logic [31:0] da,
                       input logic vb, input logic [4:0] ab, input logic [31:0] db,
                       input logic st, input logic [4:0] lk);
    resultValidA = va; resultAddressA = aa; resultDataA = da;
    resultValidB = vb; resultAddressB = ab; resultDataB = db;
    writeStall = st; lookupAddress = lk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference: a plain FIFO of accepted results; drains come from its head.
  task automatic model_step();
    int   free;
    int   nd;
    logic era, erb, ehit;
    free = DEPTH - q.size();
    era  = (free >= 1);
    erb  = (free >= 2) || (free == 1 && !resultValidA);
    nd   = writeStall ? 0 : ((q.size() >= 2) ? 2 : q.size());
    ehit = 1'b0;
    foreach (q[i]) if (q[i].a == lookupAddress) ehit = 1'b1;
    check("rnd readyA", resultReadyA, era);
    check("rnd readyB", resultReadyB, erb);
    check("rnd enableA", writeEnableA, nd >= 1);
    check("rnd enableB", writeEnableB, nd == 2);
    check("rnd pendingHit", pendingHit, ehit);
    if (nd == 1) begin
      check("rnd addrA", writeAddressA, q[0].a);
      check("rnd dataA", writeDataA, q[0].d);
    end else if (nd == 2) begin
      check("rnd addrB", writeAddressB, q[0].a);
      check("rnd dataB", writeDataB, q[0].d);
      check("rnd addrA", writeAddressA, q[1].a);
      check("rnd dataA", writeDataA, q[1].d);
    end
    if (writeEnableB) rf[writeAddressB] = writeDataB;
    if (writeEnableA) rf[writeAddressA] = writeDataA;
    for (int k = 0; k < nd; k++) void'(q.pop_front());
    if (resultValidA && era) begin
      q.push_back('{a: resultAddressA, d: resultDataA});
      last[resultAddressA] = resultDataA;
    end
    if (resultValidB && erb) begin
      q.push_back('{a: resultAddressB, d: resultDataB});
      last[resultAddressB] = resultDataB;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //        va aa  da     vb ab  db     st lk  ra rb wea waa wda    web wab wdb    hit
    vecs.push_back(v(0, 0, 0,     0, 0, 0,     0, 5,  1, 1, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(1, 5, 'h11,  0, 0, 0,     0, 5,  1, 1, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,     0, 5,  1, 1, 1, 5, 'h11,  0, 0, 0,     1));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,     0, 5,  1, 1, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(1, 3, 'hAA,  1, 3, 'hBB,  0, 3,  1, 1, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,     0, 3,  1, 1, 1, 3, 'hBB,  1, 3, 'hAA,  1));
    vecs.push_back(v(1, 10, 100,  1, 11, 101,  1, 10, 1, 1, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(1, 12, 102,  1, 13, 103,  1, 10, 1, 1, 0, 0, 0,     0, 0, 0,     1));
    vecs.push_back(v(1, 14, 104,  1, 15, 105,  1, 13, 0, 0, 0, 0, 0,     0, 0, 0,     1));
    vecs.push_back(v(1, 14, 104,  1, 15, 105,  1, 14, 0, 0, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(1, 14, 104,  1, 15, 105,  0, 10, 0, 0, 1, 11, 101,  1, 10, 100,  1));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,     0, 12, 1, 1, 1, 13, 103,  1, 12, 102,  1));
    vecs.push_back(v(1, 1, 1,     1, 2, 2,     1, 1,  1, 1, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(1, 3, 3,     0, 0, 0,     1, 2,  1, 1, 0, 0, 0,     0, 0, 0,     1));
    vecs.push_back(v(0, 0, 0,     1, 4, 4,     1, 4,  1, 1, 0, 0, 0,     0, 0, 0,     0));
    vecs.push_back(v(1, 7, 7,     1, 8, 8,     0, 7,  0, 0, 1, 2, 2,     1, 1, 1,     0));
    vecs.push_back(v(1, 5, 5,     0, 0, 0,     1, 3,  1, 1, 0, 0, 0,     0, 0, 0,     1));
    vecs.push_back(v(1, 6, 6,     1, 9, 9,     0, 5,  1, 0, 1, 4, 4,     1, 3, 3,     1));
    vecs.push_back(v(0, 0, 0,     1, 9, 9,     0, 9,  1, 1, 1, 6, 6,     1, 5, 5,     0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,     0, 9,  1, 1, 1, 9, 9,     0, 0, 0,     1));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,     0, 9,  1, 1, 0, 0, 0,     0, 0, 0,     0));

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].va, vecs[i].aa, vecs[i].da, vecs[i].vb, vecs[i].ab, vecs[i].db,
            vecs[i].st, vecs[i].lk);
      #1;
      check($sformatf("row%0d readyA", i), resultReadyA, vecs[i].ra);
      check($sformatf("row%0d readyB", i), resultReadyB, vecs[i].rb);
      check($sformatf("row%0d enableA", i), writeEnableA, vecs[i].wea);
      check($sformatf("row%0d enableB", i), writeEnableB, vecs[i].web);
      check($sformatf("row%0d pendingHit", i), pendingHit, vecs[i].hit);
      if (vecs[i].wea) begin
        check($sformatf("row%0d addrA", i), writeAddressA, vecs[i].waa);
        check($sformatf("row%0d dataA", i), writeDataA, vecs[i].wda);
      end
      if (vecs[i].web) begin
        check($sformatf("row%0d addrB", i), writeAddressB, vecs[i].wab);
        check($sformatf("row%0d dataB", i), writeDataB, vecs[i].wdb);
      end
      @(negedge clk);
    end

    // Reset while three entries are queued and about to drain.
    drive(1, 20, 'h20, 1, 21, 'h21, 1, 20);
    @(negedge clk);
    drive(1, 22, 'h22, 0, 0, 0, 1, 20);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 20);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset enableA", writeEnableA, 1'b0);
    check("midreset enableB", writeEnableB, 1'b0);
    check("midreset pendingHit", pendingHit, 1'b0);
    check("midreset readyA", resultReadyA, 1'b1);
    check("midreset readyB", resultReadyB, 1'b1);

    // Randomised traffic against the FIFO model and a register file with port-A priority.
    do_reset();
    q.delete();
    for (int r = 0; r < 32; r++) begin
      rf[r]   = '0;
      last[r] = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
      #1;
      model_step();
      @(negedge clk);
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      model_step();
      @(negedge clk);
    end
    check("final queue empty", q.size(), 0);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("final r%0d", r), rf[r], last[r]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
